// File: rtl/inst_buffer_pkg.sv
// Shared constants for the instruction buffer: flush causes, packet width and default depth.
package inst_buffer_pkg;

    localparam int unsigned INST_BUF_DEPTH   = 16;
    localparam int unsigned BPB_PACKET_WIDTH = 8;

    typedef enum logic {
        EXCEPTION                = 1'b0,
        FAILED_BRANCH_PREDICTION = 1'b1
    } flush_cause_e;

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side push bus, decode-side output bus and pipeline control for inst_buffer.
interface inst_buffer_if #(
    parameter int unsigned AW    = 4,
    parameter int unsigned PKT_W = 8
);
    logic             flush;
    logic             flush_cause;
    logic             keep_ds;
    logic             stall;
    logic [1:0]       issue_cnt;
    logic             push_en1;
    logic             push_en2;
    logic [31:0]      push_inst1;
    logic [31:0]      push_inst2;
    logic [31:0]      push_addr1;
    logic [31:0]      push_addr2;
    logic [PKT_W-1:0] push_pkt1;
    logic [PKT_W-1:0] push_pkt2;
    logic             out_valid1;
    logic             out_valid2;
    logic [31:0]      out_inst1;
    logic [31:0]      out_inst2;
    logic [31:0]      out_addr1;
    logic [31:0]      out_addr2;
    logic [PKT_W-1:0] out_pkt1;
    logic [PKT_W-1:0] out_pkt2;
    logic             buf_full;
    logic [AW:0]      count;

    modport master (
        output flush, flush_cause, keep_ds, stall, issue_cnt,
        output push_en1, push_en2, push_inst1, push_inst2,
        output push_addr1, push_addr2, push_pkt1, push_pkt2,
        input  out_valid1, out_valid2, out_inst1, out_inst2,
        input  out_addr1, out_addr2, out_pkt1, out_pkt2, buf_full, count
    );

    modport slave (
        input  flush, flush_cause, keep_ds, stall, issue_cnt,
        input  push_en1, push_en2, push_inst1, push_inst2,
        input  push_addr1, push_addr2, push_pkt1, push_pkt2,
        output out_valid1, out_valid2, out_inst1, out_inst2,
        output out_addr1, out_addr2, out_pkt1, out_pkt2, buf_full, count
    );

endinterface

// File: rtl/inst_buf_ram.sv
// Instruction buffer storage: two synchronous write ports (port 2 wins on collision),
// two asynchronous read ports, no reset on the array.
module inst_buf_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned W     = 72
) (
    input  logic          clk,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  logic [W-1:0]  wdata1,
    input  logic          we2,
    input  logic [AW-1:0] waddr2,
    input  logic [W-1:0]  wdata2,
    input  logic [AW-1:0] raddr1,
    output logic [W-1:0]  rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [W-1:0]  rdata2
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we1) mem_d[waddr1] = wdata1;
        if (we2) mem_d[waddr2] = wdata2;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata1 = mem_q[raddr1];
    assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/inst_buffer.sv
// Dual-issue instruction FIFO between fetch and decode with delay-slot-preserving flush.
// Optional same-cycle push-to-output bypass enabled by defining INST_BUF_BYPASS_EN.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = INST_BUF_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned PKT_W = BPB_PACKET_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    inst_buffer_if.slave bus
);

    localparam int unsigned W = 64 + PKT_W;
    localparam logic [AW:0] FULL_LIMIT = (AW+1)'(DEPTH - 2);

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    issue_sat, pushes, pops;
    logic          push_ok, keep_head;
    logic          we1, we2;
    logic [AW-1:0] waddr1, waddr2;
    logic [W-1:0]  entry1, entry2, rdata1, rdata2;

    assign entry1 = {bus.push_pkt1, bus.push_addr1, bus.push_inst1};
    assign entry2 = {bus.push_pkt2, bus.push_addr2, bus.push_inst2};

    assign bus.buf_full = count_q > FULL_LIMIT;
    assign bus.count    = count_q;

    assign issue_sat = (bus.issue_cnt == 2'd3) ? 2'd2 : bus.issue_cnt;
    assign push_ok   = bus.push_en1 && !bus.buf_full;
    assign pushes    = !push_ok ? 2'd0 : (bus.push_en2 ? 2'd2 : 2'd1);
    assign pops      = bus.stall ? 2'd0 :
                       (count_q < (AW+1)'(issue_sat)) ? count_q[1:0] : issue_sat;
    assign keep_head = (bus.flush_cause == FAILED_BRANCH_PREDICTION) && bus.keep_ds
                       && (count_q != '0);

`ifdef INST_BUF_BYPASS_EN
    logic       bypass;
    logic [1:0] bp_req, bp_pops;

    assign bypass  = (count_q == '0) && bus.push_en1 && !bus.flush;
    assign bp_req  = bus.stall ? 2'd0 : issue_sat;
    assign bp_pops = (bp_req < pushes) ? bp_req : pushes;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we1     = 1'b0;
        we2     = 1'b0;
        waddr1  = tail_q;
        waddr2  = tail_q + AW'(1);
        if (bus.flush) begin
            if (keep_head) begin
                tail_d  = head_q + AW'(1);
                count_d = (AW+1)'(1);
            end else begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end else begin
`ifdef INST_BUF_BYPASS_EN
            // Entries consumed straight off the push bus never reach storage, so only
            // the unconsumed tail of the push is written and head stays put.
            if (bypass) begin
                we1     = (bp_pops == 2'd0);
                we2     = (pushes == 2'd2) && (bp_pops != 2'd2);
                waddr2  = (bp_pops == 2'd0) ? tail_q + AW'(1) : tail_q;
                tail_d  = tail_q + AW'(pushes - bp_pops);
                count_d = (AW+1)'(pushes - bp_pops);
            end else
`endif
            begin
                we1     = push_ok;
                we2     = push_ok && bus.push_en2;
                tail_d  = tail_q + AW'(pushes);
                head_d  = head_q + AW'(pops);
                count_d = count_q + (AW+1)'(pushes) - (AW+1)'(pops);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    inst_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (W)
    ) u_ram (
        .clk    (clk),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (entry1),
        .we2    (we2),
        .waddr2 (waddr2),
        .wdata2 (entry2),
        .raddr1 (head_q),
        .rdata1 (rdata1),
        .raddr2 (head_q + AW'(1)),
        .rdata2 (rdata2)
    );

    always_comb begin
        bus.out_valid1 = count_q != '0;
        bus.out_valid2 = count_q > (AW+1)'(1);
        {bus.out_pkt1, bus.out_addr1, bus.out_inst1} = bus.out_valid1 ? rdata1 : '0;
        {bus.out_pkt2, bus.out_addr2, bus.out_inst2} = bus.out_valid2 ? rdata2 : '0;
`ifdef INST_BUF_BYPASS_EN
        if (bypass) begin
            bus.out_valid1 = 1'b1;
            bus.out_valid2 = bus.push_en2;
            {bus.out_pkt1, bus.out_addr1, bus.out_inst1} = entry1;
            {bus.out_pkt2, bus.out_addr2, bus.out_inst2} = bus.push_en2 ? entry2 : '0;
        end
`endif
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: queue-based reference model compared every cycle,
// plus hand-computed expectations for each scenario.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned PKT_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   check_en = 1'b0;

    inst_buffer_if #(.AW(AW), .PKT_W(PKT_W)) bus ();

    inst_buffer #(.DEPTH(DEPTH), .AW(AW), .PKT_W(PKT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      inst;
        logic [31:0]      addr;
        logic [PKT_W-1:0] pkt;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e;
    int unsigned m_n, m_want, m_pop;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic logic [PKT_W-1:0] pkt_of(input logic [31:0] a);
        return a[PKT_W+1:2];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is just an ordered queue of instructions.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else if (bus.flush) begin
            if (bus.flush_cause == FAILED_BRANCH_PREDICTION && bus.keep_ds && mq.size() > 0) begin
                m_e = mq[0];
                mq.delete();
                mq.push_back(m_e);
            end else begin
                mq.delete();
            end
        end else begin
            m_n    = mq.size();
            m_want = bus.stall ? 0 : (bus.issue_cnt == 2'd3 ? 2 : int'(bus.issue_cnt));
            m_pop  = (m_want < m_n) ? m_want : m_n;
            repeat (m_pop) void'(mq.pop_front());
            if (bus.push_en1 && (DEPTH - m_n) >= 2) begin
                mq.push_back('{bus.push_inst1, bus.push_addr1, bus.push_pkt1});
                if (bus.push_en2)
                    mq.push_back('{bus.push_inst2, bus.push_addr2, bus.push_pkt2});
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("m_count", 64'(bus.count), 64'(mq.size()));
            chk("m_full", 64'(bus.buf_full), 64'((DEPTH - mq.size()) < 2));
            chk("m_valid1", 64'(bus.out_valid1), 64'(mq.size() >= 1));
            chk("m_valid2", 64'(bus.out_valid2), 64'(mq.size() >= 2));
            chk("m_slot1", {bus.out_addr1, bus.out_inst1},
                mq.size() >= 1 ? {mq[0].addr, mq[0].inst} : 64'd0);
            chk("m_pkt1", 64'(bus.out_pkt1), mq.size() >= 1 ? 64'(mq[0].pkt) : 64'd0);
            chk("m_slot2", {bus.out_addr2, bus.out_inst2},
                mq.size() >= 2 ? {mq[1].addr, mq[1].inst} : 64'd0);
            chk("m_pkt2", 64'(bus.out_pkt2), mq.size() >= 2 ? 64'(mq[1].pkt) : 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.flush_cause = EXCEPTION;
        bus.keep_ds     = 1'b0;
        bus.stall       = 1'b0;
        bus.issue_cnt   = 2'd0;
        bus.push_en1    = 1'b0;
        bus.push_en2    = 1'b0;
        bus.push_inst1  = '0;
        bus.push_inst2  = '0;
        bus.push_addr1  = '0;
        bus.push_addr2  = '0;
        bus.push_pkt1   = '0;
        bus.push_pkt2   = '0;
    endtask

    task automatic set_push(input logic [31:0] a, input bit two);
        bus.push_en1   = 1'b1;
        bus.push_en2   = two;
        bus.push_addr1 = a;
        bus.push_inst1 = inst_of(a);
        bus.push_pkt1  = pkt_of(a);
        bus.push_addr2 = a + 32'd4;
        bus.push_inst2 = inst_of(a + 32'd4);
        bus.push_pkt2  = pkt_of(a + 32'd4);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic fill5(input logic [31:0] base);
        set_push(base, 1'b1);          step();
        set_push(base + 32'd8, 1'b1);  step();
        set_push(base + 32'd16, 1'b0); step();
        idle();
    endtask

    logic [31:0] exp_pc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state
        do_reset();
        check_en = 1'b1;
        chk("t1_count", 64'(bus.count), 64'd0);
        chk("t1_valid", {bus.out_valid1, bus.out_valid2}, 64'd0);
        chk("t1_full", 64'(bus.buf_full), 64'd0);
        chk("t1_out", {bus.out_addr1, bus.out_inst1}, 64'd0);
        step();

        // 2: push two, then issue one
        set_push(32'h1000, 1'b1);
        step();
        idle();
        bus.issue_cnt = 2'd1;
        chk("t2_addr1_pre", 64'(bus.out_addr1), 64'h1000);
        chk("t2_addr2_pre", 64'(bus.out_addr2), 64'h1004);
        step();
        idle();
        chk("t2_addr1_post", 64'(bus.out_addr1), 64'h1004);
        chk("t2_valid2_post", 64'(bus.out_valid2), 64'd0);
        chk("t2_count_post", 64'(bus.count), 64'd1);

        // 3: fill until buf_full, then a dropped push
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_push(32'h3000 + 32'(i * 8), 1'b1);
            step();
        end
        idle();
        chk("t3_count14", 64'(bus.count), 64'd14);
        chk("t3_full14", 64'(bus.buf_full), 64'd0);
        set_push(32'h3038, 1'b1);
        step();
        chk("t3_count16", 64'(bus.count), 64'd16);
        chk("t3_full16", 64'(bus.buf_full), 64'd1);
        set_push(32'h3040, 1'b1);
        step();
        idle();
        chk("t3_dropped", 64'(bus.count), 64'd16);
        chk("t3_head", 64'(bus.out_addr1), 64'h3000);

        // 4: steady push 2 / pop 2 across the head wrap
        do_reset();
        set_push(32'h2000, 1'b1); step();
        set_push(32'h2008, 1'b1); step();
        exp_pc = 32'h2000;
        for (int i = 0; i < 20; i++) begin
            set_push(32'h2010 + 32'(i * 8), 1'b1);
            bus.issue_cnt = (i % 2 == 0) ? 2'd2 : 2'd3;
            chk("t4_issue1", 64'(bus.out_addr1), 64'(exp_pc));
            chk("t4_issue2", 64'(bus.out_addr2), 64'(exp_pc + 32'd4));
            exp_pc = exp_pc + 32'd8;
            step();
            chk("t4_count", 64'(bus.count), 64'd4);
        end
        idle();

        // 5: mispredict flush keeping the delay slot, with a same-cycle push and issue
        do_reset();
        fill5(32'h4000);
        chk("t5_count5", 64'(bus.count), 64'd5);
        bus.flush       = 1'b1;
        bus.flush_cause = FAILED_BRANCH_PREDICTION;
        bus.keep_ds     = 1'b1;
        bus.issue_cnt   = 2'd2;
        set_push(32'h5000, 1'b1);
        step();
        idle();
        chk("t5_count", 64'(bus.count), 64'd1);
        chk("t5_head", 64'(bus.out_addr1), 64'h4000);
        chk("t5_valid2", 64'(bus.out_valid2), 64'd0);
        step();
        chk("t5_count_later", 64'(bus.count), 64'd1);

        // 6: exception flush, then stall blocks pops
        do_reset();
        fill5(32'h6000);
        bus.flush       = 1'b1;
        bus.flush_cause = EXCEPTION;
        bus.keep_ds     = 1'b1;
        step();
        idle();
        chk("t6_count", 64'(bus.count), 64'd0);
        chk("t6_valid1", 64'(bus.out_valid1), 64'd0);
        set_push(32'h7000, 1'b1);
        step();
        idle();
        bus.stall     = 1'b1;
        bus.issue_cnt = 2'd2;
        step();
        idle();
        chk("t6_stall_count", 64'(bus.count), 64'd2);
        chk("t6_stall_head", 64'(bus.out_addr1), 64'h7000);

        // push_en2 alone is ignored
        bus.push_en2   = 1'b1;
        bus.push_addr2 = 32'h7100;
        step();
        idle();
        chk("t7_en2_only", 64'(bus.count), 64'd2);
        step();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
